// File: rtl/int_to_float.sv
// -----------------------------------------------------------------------------
// int_to_float
//   Multi-cycle integer to IEEE-754-style floating point converter.
//   Takes an INT_W-bit operand (signed or unsigned, chosen per transaction) and
//   returns {sign, biased exponent, fraction} rounded to nearest-even, with an
//   inexact flag. Normalisation shifts one bit per cycle.
//
// Parameters
//   INT_W : integer operand width (needs 2^(EXP_W-1) > INT_W)
//   EXP_W : exponent field width, bias = 2^(EXP_W-1)-1
//   MAN_W : stored fraction width (hidden bit not stored)
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   in_valid     in   input_a / in_signed valid
//   in_ready     out  block idle and able to accept an operand
//   input_a      in   integer operand
//   in_signed    in   1 = two's complement, 0 = unsigned
//   out_valid    out  output_z / out_inexact valid
//   out_ready    in   consumer accepts the result
//   output_z     out  {sign, biased exponent, fraction}
//   out_inexact  out  result was rounded
//   o_dbg_state  out  current FSM state
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds its data stable while valid is high and
// ready is low; valid never drops without a transfer. Only one operand is in
// flight, so in_ready is high only while idle.
// -----------------------------------------------------------------------------
module int_to_float #(
    parameter int INT_W = 32,
    parameter int EXP_W = 11,
    parameter int MAN_W = 52
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INT_W-1:0]       input_a,
    input  logic                   in_signed,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   output_z,
    output logic                   out_inexact,
    output logic [2:0]             o_dbg_state
);

    // Fraction bits available below the leading one, and the width of the
    // rounding window: those bits padded on the right with MAN_W+2 zeros, so
    // guard/round/sticky read as zero whenever the conversion is exact.
    localparam int FW = INT_W - 1;
    localparam int XW = FW + MAN_W + 2;

    localparam logic [INT_W-1:0] ONE_I    = {{(INT_W-1){1'b0}}, 1'b1};
    localparam logic [EXP_W-1:0] ONE_E    = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [EXP_W-1:0] EXP_TOP  = EXP_W'(INT_W - 1);
    localparam logic [EXP_W-1:0] BIAS_V   = EXP_W'((2 ** (EXP_W - 1)) - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ABS   = 3'd1,
        S_NORM  = 3'd2,
        S_ROUND = 3'd3,
        S_PACK  = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    state_t                 r_state;
    logic [INT_W-1:0]       r_a;
    logic                   r_signed;
    logic                   r_sign;
    logic                   r_zero;
    logic [INT_W-1:0]       r_mag;
    logic [EXP_W-1:0]       r_exp;
    logic [MAN_W-1:0]       r_frac;
    logic                   r_inexact;
    logic                   r_out_valid;
    logic [EXP_W+MAN_W:0]   r_out_z;
    logic                   r_out_inexact;

    logic                   w_neg;
    logic [INT_W-1:0]       w_abs;
    logic [XW-1:0]          w_ext;
    logic [MAN_W-1:0]       w_trunc;
    logic                   w_guard;
    logic                   w_rnd;
    logic                   w_sticky;
    logic                   w_round_up;
    logic [MAN_W:0]         w_inc;
    logic [EXP_W-1:0]       w_biased;

    // Magnitude is taken INT_W bits wide and read as unsigned, so the most
    // negative signed operand gives 2^(INT_W-1) without needing an extra bit.
    assign w_neg = r_signed & r_a[INT_W-1];
    assign w_abs = w_neg ? (~r_a + ONE_I) : r_a;

    // Rounding window over the bits below the (now normalised) leading one.
    assign w_ext      = {r_mag[INT_W-2:0], {(MAN_W+2){1'b0}}};
    assign w_trunc    = w_ext[XW-1 -: MAN_W];
    assign w_guard    = w_ext[FW+1];
    assign w_rnd      = w_ext[FW];
    assign w_sticky   = |w_ext[FW-1:0];
    assign w_round_up = w_guard & (w_rnd | w_sticky | w_trunc[0]);
    assign w_inc      = {1'b0, w_trunc} + {{MAN_W{1'b0}}, w_round_up};

    assign w_biased   = r_exp + BIAS_V;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_a           <= '0;
            r_signed      <= 1'b0;
            r_sign        <= 1'b0;
            r_zero        <= 1'b0;
            r_mag         <= '0;
            r_exp         <= '0;
            r_frac        <= '0;
            r_inexact     <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_z       <= '0;
            r_out_inexact <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a      <= input_a;
                        r_signed <= in_signed;
                        r_state  <= S_ABS;
                    end
                end
                S_ABS: begin
                    r_sign    <= w_neg;
                    r_mag     <= w_abs;
                    r_exp     <= EXP_TOP;
                    r_frac    <= '0;
                    r_inexact <= 1'b0;
                    r_zero    <= (r_a == '0);
                    // Zero skips normalisation and rounding; it still passes
                    // through PACK so the result register has a single writer.
                    r_state   <= (r_a == '0) ? S_PACK : S_NORM;
                end
                S_NORM: begin
                    if (r_mag[INT_W-1]) begin
                        r_state <= S_ROUND;
                    end else begin
                        r_mag <= r_mag << 1;
                        r_exp <= r_exp - ONE_E;
                    end
                end
                S_ROUND: begin
                    // On carry-out the low MAN_W bits of w_inc are already 0.
                    r_frac    <= w_inc[MAN_W-1:0];
                    r_inexact <= w_guard | w_rnd | w_sticky;
                    if (w_inc[MAN_W]) begin
                        r_exp <= r_exp + ONE_E;
                    end
                    r_state   <= S_PACK;
                end
                S_PACK: begin
                    r_out_z       <= r_zero ? '0 : {r_sign, w_biased, r_frac};
                    r_out_inexact <= r_inexact;
                    r_out_valid   <= 1'b1;
                    r_state       <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = r_out_valid;
    assign output_z    = r_out_z;
    assign out_inexact = r_out_inexact;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_int_to_float.sv
// -----------------------------------------------------------------------------
// tb_int_to_float
//   Drives two converters (double-like 32/11/52 and single-like 32/8/23) with
//   the same operand stream and checks results, inexact flags and latency
//   against a quotient/remainder round-to-nearest-even reference model.
// -----------------------------------------------------------------------------
module tb_int_to_float;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid;
    logic        in_signed;
    logic        out_ready;
    logic [31:0] input_a;

    logic        rdy64, val64, inx64;
    logic [63:0] z64;
    logic [2:0]  st64;
    logic        rdy32, val32, inx32;
    logic [31:0] z32;
    logic [2:0]  st32;

    int n_tests = 0;
    int n_fail  = 0;

    int_to_float #(.INT_W(32), .EXP_W(11), .MAN_W(52)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64),
        .input_a(input_a), .in_signed(in_signed), .out_valid(val64),
        .out_ready(out_ready), .output_z(z64), .out_inexact(inx64),
        .o_dbg_state(st64)
    );

    int_to_float #(.INT_W(32), .EXP_W(8), .MAN_W(23)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
        .input_a(input_a), .in_signed(in_signed), .out_valid(val32),
        .out_ready(out_ready), .output_z(z32), .out_inexact(inx32),
        .o_dbg_state(st32)
    );

    // ---------------- reference model ----------------
    // Returns {inexact, z}. Rounds the true magnitude by quotient/remainder.
    function automatic logic [64:0] ref_conv(input logic [31:0] a, input logic s,
                                             input int exp_w, input int man_w);
        logic        sg;
        logic [63:0] mag, q, rem, half, z;
        int          p, e, sh;
        sg  = s & a[31];
        mag = sg ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
        if (mag == 64'd0) return '0;
        p = 0;
        for (int i = 0; i < 64; i++) if (mag[i]) p = i;
        e   = p;
        rem = 64'd0;
        if (p <= man_w) begin
            q = mag << (man_w - p);
        end else begin
            sh   = p - man_w;
            q    = mag >> sh;
            rem  = mag & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
            if (q == (64'd1 << (man_w + 1))) begin
                q = q >> 1;
                e = e + 1;
            end
        end
        z = ({63'd0, sg} << (exp_w + man_w))
          | (64'(e + (1 << (exp_w - 1)) - 1) << man_w)
          | (q - (64'd1 << man_w));
        return {rem != 64'd0, z};
    endfunction

    function automatic int ref_lat(input logic [31:0] a, input logic s);
        logic [32:0] mag;
        int p;
        mag = (s & a[31]) ? (33'h1_0000_0000 - {1'b0, a}) : {1'b0, a};
        if (mag == 33'd0) return 2;
        p = 0;
        for (int i = 0; i < 33; i++) if (mag[i]) p = i;
        return 4 + 31 - p;
    endfunction

    // ---------------- driver ----------------
    // Feeds one operand to both converters with out_ready=1 and captures each
    // result on the first cycle its out_valid is seen. Returns at the falling
    // edge just before the output handshake edge.
    task automatic run_txn(input logic [31:0] a, input logic s,
                           output logic [63:0] rz64, output logic rx64,
                           output logic [31:0] rz32, output logic rx32,
                           output int l64, output int l32, output bit to);
        bit d64, d32;
        int k;
        to = 1'b0; d64 = 1'b0; d32 = 1'b0;
        l64 = -1; l32 = -1; rz64 = '0; rz32 = '0; rx64 = 1'b0; rx32 = 1'b0;
        @(negedge clk);
        k = 0;
        while (!(rdy64 && rdy32) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!(rdy64 && rdy32)) begin
            to = 1'b1;
            return;
        end
        input_a   = a;
        in_signed = s;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);               // accepting edge E0
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 1; c <= 100 && !(d64 && d32); c++) begin
            @(posedge clk);
            @(negedge clk);
            if (!d64 && val64) begin d64 = 1'b1; l64 = c; rz64 = z64; rx64 = inx64; end
            if (!d32 && val32) begin d32 = 1'b1; l32 = c; rz32 = z32; rx32 = inx32; end
        end
        if (!(d64 && d32)) to = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; input_a = 32'd5; in_signed = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++; if (val64 !== 1'b0 || val32 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b/%b want 0/0", val64, val32); end
        n_tests++; if (z64 !== 64'd0 || z32 !== 32'd0) begin n_fail++; $display("FAIL reset_output_z got %h/%h want 0/0", z64, z32); end
        n_tests++; if (inx64 !== 1'b0 || inx32 !== 1'b0) begin n_fail++; $display("FAIL reset_inexact got %b/%b want 0/0", inx64, inx32); end
        n_tests++; if (rdy64 !== 1'b1 || rdy32 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b/%b want 1/1", rdy64, rdy32); end
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (rdy64 !== 1'b1 || val64 !== 1'b0 || rdy32 !== 1'b1 || val32 !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle got rdy %b/%b val %b/%b want 1/1 0/0", rdy64, rdy32, val64, val32);
        end
    endtask

    task automatic test_default_vectors();
        logic [31:0] va [5];
        logic        vs [5];
        logic [63:0] e64 [5];
        logic [31:0] e32 [5];
        int          el [5];
        logic [63:0] rz64; logic [31:0] rz32; logic rx64, rx32; int l64, l32; bit to;
        va  = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000};
        vs  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        e64 = '{64'h3FF0_0000_0000_0000, 64'hBFF0_0000_0000_0000, 64'h0,
                64'hC1E0_0000_0000_0000, 64'h41E0_0000_0000_0000};
        e32 = '{32'h3F80_0000, 32'hBF80_0000, 32'h0, 32'hCF00_0000, 32'h4F00_0000};
        el  = '{35, 35, 2, 4, 4};
        for (int i = 0; i < 5; i++) begin
            run_txn(va[i], vs[i], rz64, rx64, rz32, rx32, l64, l32, to);
            n_tests++; if (to) begin n_fail++; $display("FAIL default_timeout a=%h", va[i]); end
            n_tests++; if (rz64 !== e64[i]) begin n_fail++; $display("FAIL default_z64 a=%h s=%b got %h want %h", va[i], vs[i], rz64, e64[i]); end
            n_tests++; if (rz32 !== e32[i]) begin n_fail++; $display("FAIL default_z32 a=%h s=%b got %h want %h", va[i], vs[i], rz32, e32[i]); end
            n_tests++; if (rx64 !== 1'b0 || rx32 !== 1'b0) begin n_fail++; $display("FAIL default_inexact a=%h got %b/%b want 0/0", va[i], rx64, rx32); end
            n_tests++; if (l64 != el[i] || l32 != el[i]) begin n_fail++; $display("FAIL default_latency a=%h got %0d/%0d want %0d", va[i], l64, l32, el[i]); end
        end
    endtask

    task automatic test_rounding32();
        logic [31:0] va [3];
        logic [31:0] e32 [3];
        int          el [3];
        logic [64:0] r64;
        logic [63:0] rz64; logic [31:0] rz32; logic rx64, rx32; int l64, l32; bit to;
        va  = '{32'h0100_0001, 32'h0100_0003, 32'hFFFF_FFFF};
        e32 = '{32'h4B80_0000, 32'h4B80_0002, 32'h4F80_0000};
        el  = '{11, 11, 4};
        for (int i = 0; i < 3; i++) begin
            run_txn(va[i], 1'b0, rz64, rx64, rz32, rx32, l64, l32, to);
            r64 = ref_conv(va[i], 1'b0, 11, 52);
            n_tests++; if (to) begin n_fail++; $display("FAIL round_timeout a=%h", va[i]); end
            n_tests++; if (rz32 !== e32[i] || rx32 !== 1'b1) begin n_fail++; $display("FAIL round_z32 a=%h got %h inx %b want %h inx 1", va[i], rz32, rx32, e32[i]); end
            n_tests++; if (rz64 !== r64[63:0] || rx64 !== r64[64]) begin n_fail++; $display("FAIL round_z64 a=%h got %h inx %b want %h inx %b", va[i], rz64, rx64, r64[63:0], r64[64]); end
            n_tests++; if (l32 != el[i] || l64 != el[i]) begin n_fail++; $display("FAIL round_latency a=%h got %0d/%0d want %0d", va[i], l64, l32, el[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a; logic s;
        logic [64:0] r64, r32;
        logic [63:0] rz64; logic [31:0] rz32; logic rx64, rx32; int l64, l32; bit to;
        for (int i = 0; i < 8; i++) begin
            a = $urandom >> $urandom_range(0, 24);
            s = 1'($urandom_range(0, 1));
            run_txn(a, s, rz64, rx64, rz32, rx32, l64, l32, to);
            r64 = ref_conv(a, s, 11, 52);
            r32 = ref_conv(a, s, 8, 23);
            n_tests++; if (to) begin n_fail++; $display("FAIL b2b_timeout a=%h", a); end
            n_tests++; if (rz64 !== r64[63:0] || rz32 !== r32[31:0]) begin
                n_fail++; $display("FAIL b2b_result a=%h s=%b got %h/%h want %h/%h", a, s, rz64, rz32, r64[63:0], r32[31:0]);
            end
            @(posedge clk);           // output handshake edge
            @(negedge clk);
            n_tests++; if (rdy64 !== 1'b1 || val64 !== 1'b0 || rdy32 !== 1'b1 || val32 !== 1'b0) begin
                n_fail++; $display("FAIL b2b_release rdy %b/%b val %b/%b want 1/1 0/0", rdy64, rdy32, val64, val32);
            end
        end
    endtask

    task automatic test_backpressure();
        int k;
        int extra;
        @(negedge clk);
        input_a = 32'd3; in_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (!(val64 && val32) && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_tests++; if (!(val64 && val32)) begin n_fail++; $display("FAIL bp_timeout val %b/%b want 1/1", val64, val32); end
        for (int i = 0; i < 10; i++) begin
            input_a  = $urandom;
            in_valid = (i % 2 == 0);
            @(posedge clk);
            @(negedge clk);
            n_tests++; if (val64 !== 1'b1 || z64 !== 64'h4008_0000_0000_0000 || inx64 !== 1'b0 || rdy64 !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold64 cyc %0d got val %b z %h inx %b rdy %b want 1 4008000000000000 0 0", i, val64, z64, inx64, rdy64);
            end
            n_tests++; if (val32 !== 1'b1 || z32 !== 32'h4040_0000 || inx32 !== 1'b0 || rdy32 !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold32 cyc %0d got val %b z %h inx %b rdy %b want 1 40400000 0 0", i, val32, z32, inx32, rdy32);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_tests++; if (val64 !== 1'b0 || rdy64 !== 1'b1 || val32 !== 1'b0 || rdy32 !== 1'b1) begin
            n_fail++; $display("FAIL bp_release val %b/%b rdy %b/%b want 0/0 1/1", val64, val32, rdy64, rdy32);
        end
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (val64 || val32) extra++;
        end
        n_tests++; if (extra != 0) begin n_fail++; $display("FAIL bp_single_handshake extra valid cycles got %0d want 0", extra); end
    endtask

    task automatic test_reset_during_norm();
        int extra;
        logic [63:0] rz64; logic [31:0] rz32; logic rx64, rx32; int l64, l32; bit to;
        @(negedge clk);
        input_a = 32'd1; in_signed = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);               // E0
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);   // E0+10
        #1 rst = 1'b1;
        #1;
        n_tests++; if (val64 !== 1'b0 || val32 !== 1'b0 || rdy64 !== 1'b1 || rdy32 !== 1'b1) begin
            n_fail++; $display("FAIL abort_state val %b/%b rdy %b/%b want 0/0 1/1", val64, val32, rdy64, rdy32);
        end
        n_tests++; if (z64 !== 64'd0 || z32 !== 32'd0) begin n_fail++; $display("FAIL abort_output_z got %h/%h want 0/0", z64, z32); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (val64 || val32) extra++;
        end
        n_tests++; if (extra != 0) begin n_fail++; $display("FAIL abort_no_result valid cycles got %0d want 0", extra); end
        run_txn(32'h0000_0010, 1'b1, rz64, rx64, rz32, rx32, l64, l32, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL after_abort_timeout"); end
        n_tests++; if (rz64 !== 64'h4030_0000_0000_0000 || rz32 !== 32'h4180_0000) begin
            n_fail++; $display("FAIL after_abort_result got %h/%h want 4030000000000000/41800000", rz64, rz32);
        end
        n_tests++; if (l64 != 31 || l32 != 31) begin n_fail++; $display("FAIL after_abort_latency got %0d/%0d want 31", l64, l32); end
    endtask

    task automatic test_random();
        logic [31:0] a; logic s;
        logic [64:0] r64, r32;
        int el;
        logic [63:0] rz64; logic [31:0] rz32; logic rx64, rx32; int l64, l32; bit to;
        for (int i = 0; i < 4000; i++) begin
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = a >> $urandom_range(0, 31);
            if ($urandom_range(0, 63) == 0) a = 32'd0;
            s = 1'($urandom_range(0, 1));
            run_txn(a, s, rz64, rx64, rz32, rx32, l64, l32, to);
            r64 = ref_conv(a, s, 11, 52);
            r32 = ref_conv(a, s, 8, 23);
            el  = ref_lat(a, s);
            n_tests++; if (to) begin n_fail++; $display("FAIL rand_timeout a=%h s=%b", a, s); end
            n_tests++; if (rz64 !== r64[63:0] || rx64 !== r64[64]) begin
                n_fail++; $display("FAIL rand_z64 a=%h s=%b got %h inx %b want %h inx %b", a, s, rz64, rx64, r64[63:0], r64[64]);
            end
            n_tests++; if (rz32 !== r32[31:0] || rx32 !== r32[64]) begin
                n_fail++; $display("FAIL rand_z32 a=%h s=%b got %h inx %b want %h inx %b", a, s, rz32, rx32, r32[31:0], r32[64]);
            end
            n_tests++; if (l64 != el || l32 != el) begin
                n_fail++; $display("FAIL rand_latency a=%h s=%b got %0d/%0d want %0d", a, s, l64, l32, el);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_default_vectors();
        test_rounding32();
        test_back_to_back();
        test_backpressure();
        test_reset_during_norm();
        test_random();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
